// File: rtl/idu0_queue_pkg.sv
// Shared types for the IDU0 decode queue: architectural widths, decode
// control flags, the queued entry layout and the immediate generator.
package idu0_queue_pkg;

    localparam int XLEN      = 32;
    localparam int INSTR_LEN = 32;

    typedef struct packed {
        logic legal;
        logic alu;
        logic load;
        logic store;
        logic condbr;
        logic jal;
        logic jalr;
        logic pc;
        logic imm12;
        logic imm20;
    } decode_out_t;

    typedef struct packed {
        logic [INSTR_LEN-1:0] instr;
        logic [XLEN-1:0]      tag;
        logic [4:0]           rs1_addr;
        logic [4:0]           rs2_addr;
        logic [4:0]           rd_addr;
        logic [4:0]           shamt;
        logic [XLEN-1:0]      imm;
        logic                 imm_valid;
        decode_out_t          ctl;
    } idu0_out_t;

    // Each format is masked by its decode flag and the results OR-ed, so at
    // most one term is non-zero for any legal opcode.
    function automatic logic [XLEN-1:0] imm_gen(input logic [INSTR_LEN-1:0] instr,
                                                 input decode_out_t       dec);
        logic signed [XLEN-1:0] u_imm;
        logic signed [XLEN-1:0] j_imm;
        logic signed [XLEN-1:0] i_imm;
        logic signed [XLEN-1:0] b_imm;
        logic signed [XLEN-1:0] s_imm;
        u_imm = {instr[31:12], 12'h000};
        j_imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        i_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
        b_imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        s_imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
        imm_gen = ({XLEN{dec.imm20 & ~dec.pc}}  & u_imm)
                | ({XLEN{dec.imm20 &  dec.pc}}  & j_imm)
                | ({XLEN{dec.imm12 |  dec.load}} & i_imm)
                | ({XLEN{dec.condbr}}           & b_imm)
                | ({XLEN{dec.store}}            & s_imm);
    endfunction

endpackage

// File: rtl/idu0_queue_decode.sv
// Opcode decoder on the queue push path: classifies an RV32I opcode into
// the control flags stored alongside each queued instruction.
module idu0_queue_decode
    import idu0_queue_pkg::*;
(
    input  logic [6:0]  opcode,
    output decode_out_t dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            7'b0110111: begin dec.legal = 1'b1; dec.alu = 1'b1; dec.imm20 = 1'b1; end
            7'b0010111: begin dec.legal = 1'b1; dec.alu = 1'b1; dec.imm20 = 1'b1; end
            7'b1101111: begin dec.legal = 1'b1; dec.jal = 1'b1; dec.imm20 = 1'b1; dec.pc = 1'b1; end
            7'b1100111: begin dec.legal = 1'b1; dec.jalr = 1'b1; dec.imm12 = 1'b1; end
            7'b1100011: begin dec.legal = 1'b1; dec.condbr = 1'b1; end
            7'b0000011: begin dec.legal = 1'b1; dec.load = 1'b1; end
            7'b0100011: begin dec.legal = 1'b1; dec.store = 1'b1; end
            7'b0010011: begin dec.legal = 1'b1; dec.alu = 1'b1; dec.imm12 = 1'b1; end
            7'b0110011: begin dec.legal = 1'b1; dec.alu = 1'b1; end
            default:    dec = '0;
        endcase
    end

endmodule

// File: rtl/idu0_queue.sv
// IDU0 instruction queue: decodes on push into a circular buffer and
// presents the oldest entry through a registered head output.
module idu0_queue
    import idu0_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [INSTR_LEN-1:0]   instr,
    input  logic                   instr_valid,
    input  logic [XLEN-1:0]        instr_tag,
    output logic                   instr_ready,
    input  logic                   pipe_stall,
    input  logic                   pipe_flush,
    output idu0_out_t              idu0_out,
    output logic                   idu0_out_valid,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    idu0_out_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    decode_out_t   dec_p0;
    idu0_out_t     entry_p0;
    idu0_out_t     head_nxt;
    logic          push;
    logic          pop;
    logic          head_load;

    idu0_queue_decode u_decode (
        .opcode (instr[6:0]),
        .dec    (dec_p0)
    );

    always_comb begin
        entry_p0           = '0;
        entry_p0.instr     = instr;
        entry_p0.tag       = instr_tag;
        entry_p0.rs1_addr  = instr[19:15];
        entry_p0.rs2_addr  = instr[24:20];
        entry_p0.rd_addr   = instr[11:7];
        entry_p0.shamt     = instr[24:20];
        entry_p0.imm       = imm_gen(instr, dec_p0);
        entry_p0.imm_valid = (dec_p0.imm20 & ~dec_p0.jal) | dec_p0.imm12 | dec_p0.load | dec_p0.store;
        entry_p0.ctl       = dec_p0;
    end

    assign instr_ready = (count != FULL_CNT);
    assign push        = instr_valid & instr_ready & ~pipe_flush;
    assign pop         = idu0_out_valid & ~pipe_stall;
    assign occupancy   = count;

    // The head copy must be refreshed whenever the current head leaves or the
    // queue was empty; the replacement is either the next stored entry or the
    // instruction arriving this cycle.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        head_load = 1'b0;
        head_nxt  = entry_p0;
        if (pop) begin
            if (count >= CW'(2)) begin
                head_load = 1'b1;
                head_nxt  = mem[rd_ptr + PW'(1)];
            end else if (push) begin
                head_load = 1'b1;
            end
        end else if ((count == '0) && push) begin
            head_load = 1'b1;
        end
    end

    // Stage p0 -> p1: pointers, count and registered head.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            idu0_out_valid <= 1'b0;
            idu0_out       <= '0;
        end else if (pipe_flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            idu0_out_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count          <= count_nxt;
            idu0_out_valid <= (count_nxt != '0);
            if (head_load) idu0_out <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry_p0;
    end

endmodule

// File: doc/idu0_queue.md
IDU0_QUEUE -- requirements
Module: idu0_queue

Interface
- REQ-001 SHALL have parameter DEPTH, default 4, giving the number of decoded-instruction entries; legal values are powers of two, 2 to 16.
- REQ-002 SHALL take XLEN and INSTR_LEN from the shared package; they are not local parameters.
- REQ-003 SHALL have one clock and an asynchronous active-low reset: clk (input, 1 bit, rising-edge clock) and rstn (input, 1 bit, asynchronous active-low reset).
- REQ-004 instr  input  INSTR_LEN  raw instruction from IFU.
- REQ-005 instr_valid  input  1  IFU instruction valid.
- REQ-006 instr_tag  input  XLEN  PC/tag for the instruction.
- REQ-007 instr_ready  output  1  queue can accept; equals ~full.
- REQ-008 pipe_stall  input  1  downstream IDU1 cannot take the head entry.
- REQ-009 pipe_flush  input  1  discard all queued entries.
- REQ-010 idu0_out  output  idu0_out_t  head decoded entry, registered.
- REQ-011 idu0_out_valid  output  1  idu0_out holds a live entry.
- REQ-012 occupancy  output  $clog2(DEPTH)+1  number of live entries, including the head.

Function
- REQ-013 SHALL accept a push when instr_valid=1, instr_ready=1 and pipe_flush=0.
- REQ-014 SHALL decode at push time using the decode sub-module. The stored entry SHALL hold:
  - instr and instr_tag;
  - rs1_addr=instr[19:15], rs2_addr=instr[24:20], rd_addr=instr[11:7], shamt=instr[24:20];
  - every decode_out control field, copied unchanged.
- REQ-015 imm SHALL be the OR of the masked formats:
  - U: imm20 & ~pc gives {instr[31:12], 12'h0};
  - J: imm20 & pc;
  - I: imm12 or load;
  - B: condbr;
  - S: store.
  All formats except U are sign-extended from instr[31].
- REQ-016 imm_valid SHALL equal (imm20 & ~jal) | imm12 | load | store.
- REQ-017 SHALL pop the head when idu0_out_valid=1 and pipe_stall=0; the next entry SHALL appear on idu0_out on the following cycle.
- REQ-018 Push-to-output latency SHALL be 1 cycle when the queue is empty, and no bypass exists in the same cycle.
- REQ-019 Entries SHALL leave in push order; read and write pointers wrap modulo DEPTH.
- REQ-020 Push and pop in the same cycle SHALL leave occupancy unchanged.
- REQ-021 When full, instr_ready=0 even if a pop occurs that cycle; a push is never taken while full.
- REQ-022 When empty, idu0_out_valid=0 and idu0_out is held at its last value; pipe_stall has no effect.
- REQ-023 pipe_flush=1 SHALL, on the next edge:
  - zero both pointers and occupancy;
  - set idu0_out_valid=0;
  - override any push or pop in the same cycle.
- REQ-024 While pipe_stall=1, idu0_out SHALL stay stable and pushes SHALL still be accepted while not full.
- REQ-025 An illegal instruction (legal=0) SHALL be queued like any other entry; the queue raises no error.

Reset
- REQ-026 When rstn is low: pointers=0, occupancy=0, idu0_out_valid=0, idu0_out=all zeros, storage contents don't-care.
- REQ-027 instr_ready SHALL be 1 from the first cycle after rstn rises.
- REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Structure
- REQ-029 idu0_out_t, decode_out_t, XLEN and INSTR_LEN SHALL live in the shared types/global package; no new typedef is local to this module.
- REQ-030 SHALL instantiate exactly one decode sub-module on the push path; storage is an internal array of idu0_out_t.
- REQ-031 Output-register flops SHALL use an asynchronous reset.

Verification
- REQ-032 Reset then push ADDI x1,x0,5 (0x00500093) with tag 0x100 -> next cycle: valid=1, imm=5, imm_valid=1, rd_addr=1, occupancy=1.
- REQ-033 With pipe_stall=1, push 4 instructions (DEPTH=4) -> instr_ready=0 and occupancy=4; a 5th instr_valid is not taken; release stall -> 4 pops in order of tags 0x100, 0x104, 0x108, 0x10C.
- REQ-034 Full queue with pipe_flush=1 and instr_valid=1 in the same cycle -> next cycle: occupancy=0, valid=0, the incoming instruction dropped.
- REQ-035 Continuous push and pop for 10 cycles -> occupancy constant at 1, pointers wrap, tags in order, no bubbles.
- REQ-036 Push JAL 0xFFDFF0EF -> imm=0xFFFFFFFC and imm_valid=0; push BEQ offset -8 -> imm=0xFFFFFFF8 and imm_valid=0.
- REQ-037 Assert rstn low asynchronously with 3 entries queued -> valid=0 and occupancy=0 before the next clk edge.
